// File: rtl/c_writeback_dp_if.sv
// Port bundle for the C write-back datapath: the 2x2 result-block handshake from
// the MAC array and the single-port write channel into the column-major C RAM.
interface c_writeback_dp_if #(
  parameter int DW = 16,
  parameter int AW = 8
);
  // A block transfers on every rising edge where in_valid && in_ready; in_ready never
  // depends on in_valid, and in_valid seen while in_ready is low is dropped, not queued.
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] c00;
  logic [DW-1:0] c10;
  logic [DW-1:0] c01;
  logic [DW-1:0] c11;

  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  modport slave (
    input  in_valid, c00, c10, c01, c11,
    output in_ready, we, waddr, wdata
  );

  modport master (
    output in_valid, c00, c10, c01, c11,
    input  in_ready, we, waddr, wdata
  );
endinterface

// File: rtl/c_writeback_dp.sv
// Serialises 2x2 result blocks into four column-major C RAM writes, walking blocks
// with j inner and i outer in steps of two, and flags done after the last block.
module c_writeback_dp #(
  parameter int N  = 8,
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  c_writeback_dp_if.slave      bus,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [AW-1:0] N_A    = AW'(N);
  localparam logic [AW-1:0] LAST_A = AW'(N - 2);
  localparam logic [AW-1:0] STEP_A = AW'(2);

  state_t        state_q, state_d;
  logic [AW-1:0] bi_q, bi_d;
  logic [AW-1:0] bj_q, bj_d;
  logic [1:0]    sub_q, sub_d;
  logic [DW-1:0] d00_q, d00_d;
  logic [DW-1:0] d10_q, d10_d;
  logic [DW-1:0] d01_q, d01_d;
  logic [DW-1:0] d11_q, d11_d;

  logic          last_blk;
  logic          in_ready_w;
  logic          accept;
  logic [AW-1:0] col_w;
  logic [AW-1:0] row_w;

  assign last_blk   = (bi_q == LAST_A) && (bj_q == LAST_A);
  // Ready in sub3 lets the next block start with no bubble; never on the final block.
  assign in_ready_w = (state_q == S_WAIT) ||
                      ((state_q == S_WRITE) && (sub_q == 2'd3) && !last_blk);
  assign accept     = bus.in_valid && in_ready_w;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      bi_q    <= '0;
      bj_q    <= '0;
      sub_q   <= '0;
      d00_q   <= '0;
      d10_q   <= '0;
      d01_q   <= '0;
      d11_q   <= '0;
    end else begin
      state_q <= state_d;
      bi_q    <= bi_d;
      bj_q    <= bj_d;
      sub_q   <= sub_d;
      d00_q   <= d00_d;
      d10_q   <= d10_d;
      d01_q   <= d01_d;
      d11_q   <= d11_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bi_d    = bi_q;
    bj_d    = bj_q;
    sub_d   = sub_q;
    d00_d   = d00_q;
    d10_d   = d10_q;
    d01_d   = d01_q;
    d11_d   = d11_q;

    if (accept) begin
      d00_d = bus.c00;
      d10_d = bus.c10;
      d01_d = bus.c01;
      d11_d = bus.c11;
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_WAIT;
          bi_d    = '0;
          bj_d    = '0;
          sub_d   = '0;
        end
      end
      S_WAIT: begin
        if (accept) begin
          state_d = S_WRITE;
          sub_d   = '0;
        end
      end
      S_WRITE: begin
        if (sub_q != 2'd3) begin
          sub_d = sub_q + 2'd1;
        end else begin
          sub_d = '0;
          if (bj_q < LAST_A) begin
            bj_d = bj_q + STEP_A;
          end else begin
            bj_d = '0;
            bi_d = (bi_q < LAST_A) ? (bi_q + STEP_A) : '0;
          end
          if (last_blk) begin
            state_d = S_DONE;
          end else if (!accept) begin
            state_d = S_WAIT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // sub[1] selects column j+1, sub[0] selects row i+1; all from registered state.
  assign col_w = bj_q + {{(AW-1){1'b0}}, sub_q[1]};
  assign row_w = bi_q + {{(AW-1){1'b0}}, sub_q[0]};

  assign bus.waddr    = col_w * N_A + row_w;
  assign bus.we       = (state_q == S_WRITE);
  assign bus.in_ready = in_ready_w;

  always_comb begin
    bus.wdata = d00_q;
    unique case (sub_q)
      2'd0: bus.wdata = d00_q;
      2'd1: bus.wdata = d10_q;
      2'd2: bus.wdata = d01_q;
      2'd3: bus.wdata = d11_q;
      default: bus.wdata = d00_q;
    endcase
  end

  assign busy      = (state_q == S_WAIT) || (state_q == S_WRITE);
  assign done      = (state_q == S_DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_c_writeback_dp.sv
// Bench for c_writeback_dp: random result blocks, expected writes derived from
// block index arithmetic, a negedge monitor scoring every RAM write.
module tb_c_writeback_dp;

  localparam int N  = 8;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int NB = (N / 2) * (N / 2);

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       busy;
  logic       done;
  logic [1:0] state_dbg;

  c_writeback_dp_if #(.DW(DW), .AW(AW)) bus ();

  c_writeback_dp #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .bus       (bus.slave),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [AW+DW-1:0] exp_q[$];
  int wr_cnt[N*N];
  int wr_total = 0;
  int first_wr = -1;
  int last_wr  = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference: block k sits at row pair 2*(k / (N/2)), column pair 2*(k % (N/2)).
  function automatic int blk_row(input int k);
    return 2 * (k / (N / 2));
  endfunction
  function automatic int blk_col(input int k);
    return 2 * (k % (N / 2));
  endfunction
  function automatic int cm_addr(input int r, input int c);
    return c * N + r;
  endfunction

  task automatic push_block(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [DW-1:0] c, input logic [DW-1:0] d);
    int r, cl;
    r  = blk_row(k);
    cl = blk_col(k);
    exp_q.push_back({AW'(cm_addr(r,     cl)),     a});
    exp_q.push_back({AW'(cm_addr(r + 1, cl)),     b});
    exp_q.push_back({AW'(cm_addr(r,     cl + 1)), c});
    exp_q.push_back({AW'(cm_addr(r + 1, cl + 1)), d});
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset_n && bus.we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr %0d data %0h with nothing expected", bus.waddr, bus.wdata);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        if ({bus.waddr, bus.wdata} !== e) begin
          errors++;
          $display("FAIL write: got addr %0d data %0h expected addr %0d data %0h",
                   bus.waddr, bus.wdata, e[AW+DW-1:DW], e[DW-1:0]);
        end
        if (int'(bus.waddr) < N * N) wr_cnt[bus.waddr]++;
        wr_total++;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Call at #1 after a posedge; returns #1 after the accepting edge.
  task automatic send_block(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [DW-1:0] c, input logic [DW-1:0] d);
    bit hs;
    int budget;
    bus.in_valid = 1'b1;
    bus.c00 = a;
    bus.c10 = b;
    bus.c01 = c;
    bus.c11 = d;
    budget = 0;
    hs = 1'b0;
    while (!hs && budget < 200) begin
      @(negedge clk);
      hs = bus.in_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    if (hs) begin
      push_block(k, a, b, c, d);
    end else begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: block %0d never accepted", k);
    end
  endtask

  task automatic send_rand(input int k);
    send_block(k, DW'($urandom_range(0, 65535)), DW'($urandom_range(0, 65535)),
                  DW'($urandom_range(0, 65535)), DW'($urandom_range(0, 65535)));
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_n      = 1'b0;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.c00 = '0; bus.c10 = '0; bus.c01 = '0; bus.c11 = '0;
    foreach (wr_cnt[a]) wr_cnt[a] = 0;

    #12;
    check("rst_we",       32'(bus.we),       32'd0);
    check("rst_waddr",    32'(bus.waddr),    32'd0);
    check("rst_wdata",    32'(bus.wdata),    32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_busy",     32'(busy),         32'd0);
    check("rst_done",     32'(done),         32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Run 1: block 0 with fixed data, then a 10-cycle stall, then the rest back-to-back.
    bus.in_valid = 1'b1;  // ignored in IDLE alongside start
    pulse_start();
    check("start_busy", 32'(busy), 32'd1);
    send_block(0, 16'd1, 16'd2, 16'd3, 16'd4);
    bus.in_valid = 1'b0;
    check("t1_sub0_in_ready", 32'(bus.in_ready), 32'd0);
    tick(4);
    for (int i = 0; i < 10; i++) begin
      check("stall_we",       32'(bus.we),       32'd0);
      check("stall_in_ready", 32'(bus.in_ready), 32'd1);
      check("stall_waddr",    32'(bus.waddr),    32'(cm_addr(blk_row(1), blk_col(1))));
      tick(1);
    end
    for (int k = 1; k < NB; k++) send_rand(k);
    bus.in_valid = 1'b0;
    tick(4);
    check("run1_done", 32'(done), 32'd1);
    check("run1_queue_empty", 32'(exp_q.size()), 32'd0);

    // Run 2: full gapless run, restart from DONE, stray start mid-run.
    foreach (wr_cnt[a]) wr_cnt[a] = 0;
    wr_total = 0;
    first_wr = -1;
    last_wr  = -1;
    pulse_start();
    check("restart_done", 32'(done), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    for (int k = 0; k < NB; k++) begin
      send_rand(k);
      if (k == 3) begin
        pulse_start();
        check("stray_start_busy", 32'(busy), 32'd1);
        check("stray_start_we",   32'(bus.we), 32'd1);
      end
    end
    tick(3);
    check("last_sub3_we",       32'(bus.we),       32'd1);
    check("last_sub3_in_ready", 32'(bus.in_ready), 32'd0);
    tick(1);
    check("done_after_last",  32'(done),         32'd1);
    check("done_we",          32'(bus.we),       32'd0);
    check("done_in_ready",    32'(bus.in_ready), 32'd0);
    check("done_busy",        32'(busy),         32'd0);
    tick(5);  // in_valid still high in DONE: must be ignored
    bus.in_valid = 1'b0;
    check("done_held", 32'(done), 32'd1);
    check("run2_writes", 32'(wr_total), 32'(NB * 4));
    check("run2_no_gaps", 32'(last_wr - first_wr), 32'(NB * 4 - 1));
    for (int a = 0; a < N * N; a++) check($sformatf("cover_addr%0d", a), 32'(wr_cnt[a]), 32'd1);

    // Run 3: reset during sub1 of block 5, then restart at address 0.
    pulse_start();
    for (int k = 0; k <= 5; k++) send_rand(k);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2;
    check("pre_reset_we", 32'(bus.we), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_reset_we",   32'(bus.we),   32'd0);
    check("mid_reset_done", 32'(done),     32'd0);
    check("mid_reset_busy", 32'(busy),     32'd0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    tick(2);
    check("post_reset_idle_we", 32'(bus.we), 32'd0);
    pulse_start();
    send_rand(0);
    bus.in_valid = 1'b0;
    tick(5);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
